voice_sample_address_generator: RTL and testbench

Polyphonic successor to the single-counter sample address generator: one independent, fractional-rate playback pointer per voice, with per-voice gates and increments and shared loop points and playback mode (one-shot, forward loop, ping-pong). Sits between the voice allocator (gates, pitch increments) and the sample BRAM read ports and interpolator. All voices advance in parallel on the shared `sample_tick`.

---
 rtl/voice_sample_address_generator.sv | 153 +++++++++++++++
 tb/tb_voice_sample_address_generator.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_sample_address_generator.sv
// Polyphonic fractional-rate sample address generator: one playback pointer per voice,
// shared loop points and playback mode, all voices stepped together on sample_tick.
module voice_sample_address_generator #(
   parameter int NUM_VOICES = 8,
   parameter int ADDR_WIDTH = 13,
   parameter int FRAC_WIDTH = 8,
   parameter int INC_WIDTH  = 12
) (
   input  logic                             clk_in,
   input  logic                             rst_n_in,
   input  logic                             sample_tick,
   input  logic [NUM_VOICES-1:0]            gate_in,
   input  logic [NUM_VOICES*INC_WIDTH-1:0]  inc_in,
   input  logic [1:0]                       mode_in,
   input  logic [ADDR_WIDTH-1:0]            loop_start_in,
   input  logic [ADDR_WIDTH-1:0]            loop_end_in,
   output logic [NUM_VOICES*ADDR_WIDTH-1:0] sample_addr_out,
   output logic [NUM_VOICES*FRAC_WIDTH-1:0] frac_out,
   output logic [NUM_VOICES-1:0]            active_out,
   output logic [NUM_VOICES-1:0]            done_out,
   output logic [NUM_VOICES-1:0]            wrap_out
);

   localparam int PH_W = ADDR_WIDTH + FRAC_WIDTH;
   // Two guard bits: one for overshoot past the top address, one as sign for backward underflow.
   localparam int PS_W = PH_W + 2;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [FRAC_WIDTH-1:0] frac;
      logic                  dir;
      logic                  active;
      logic                  done;
      logic                  wrap;
   } voice_t;

   voice_t [NUM_VOICES-1:0] voice_q, voice_d;
   logic   [NUM_VOICES-1:0] gate_q, gate_d;

   function automatic voice_t advance(
      input voice_t                 cur,
      input logic [INC_WIDTH-1:0]   inc,
      input logic [1:0]             mode,
      input logic [ADDR_WIDTH-1:0]  ls,
      input logic [ADDR_WIDTH-1:0]  le
   );
      voice_t                 nxt;
      logic signed [PS_W-1:0] phase;
      logic signed [PS_W-1:0] inc_ext;
      logic signed [PS_W-1:0] start_ph;
      logic signed [PS_W-1:0] p;
      logic [ADDR_WIDTH:0]    p_int;
      logic [ADDR_WIDTH+1:0]  wrapped;
      logic                   degenerate;
      logic                   pingpong;
      logic                   looping;
      logic                   back;

      nxt        = cur;
      nxt.done   = 1'b0;
      nxt.wrap   = 1'b0;
      degenerate = (ls >= le);
      pingpong   = (mode == 2'd2) && !degenerate;
      looping    = (mode == 2'd1) && !degenerate;
      back       = pingpong && cur.dir;
      phase      = $signed({2'b00, cur.addr, cur.frac});
      inc_ext    = $signed({{(PS_W-INC_WIDTH){1'b0}}, inc});
      start_ph   = $signed({2'b00, ls, {FRAC_WIDTH{1'b0}}});
      p          = back ? (phase - inc_ext) : (phase + inc_ext);
      p_int      = p[PH_W:FRAC_WIDTH];
      wrapped    = {2'b00, ls} + ({1'b0, p_int} - {2'b00, le} - (ADDR_WIDTH+2)'(1));

      if (inc != '0) begin
         if (!pingpong) nxt.dir = 1'b0;
         nxt.addr = p_int[ADDR_WIDTH-1:0];
         nxt.frac = p[FRAC_WIDTH-1:0];
         if (back) begin
            if (p < start_ph) begin
               nxt.addr = ls;
               nxt.frac = '0;
               nxt.dir  = 1'b0;
               nxt.wrap = 1'b1;
            end
         end else if (pingpong) begin
            if (p_int > {1'b0, le}) begin
               nxt.addr = le;
               nxt.frac = '0;
               nxt.dir  = 1'b1;
               nxt.wrap = 1'b1;
            end
         end else if (looping) begin
            if (p_int > {1'b0, le}) begin
               // An increment longer than the loop cannot land inside it; restart at loop start.
               nxt.addr = (wrapped > {2'b00, le}) ? ls : wrapped[ADDR_WIDTH-1:0];
               nxt.wrap = 1'b1;
            end
         end else begin
            if (p_int >= {1'b0, le}) begin
               nxt.addr   = le;
               nxt.frac   = '0;
               nxt.active = 1'b0;
               nxt.done   = 1'b1;
            end
         end
      end
      return nxt;
   endfunction

   always_comb begin
      voice_d = voice_q;
      gate_d  = gate_in;
      for (int v = 0; v < NUM_VOICES; v++) begin
         voice_d[v].done = 1'b0;
         voice_d[v].wrap = 1'b0;
         if (!gate_in[v]) begin
            voice_d[v] = '0;
         end else if (!gate_q[v]) begin
            // Rising gate restarts the voice; a coincident tick is deliberately ignored.
            voice_d[v]        = '0;
            voice_d[v].active = 1'b1;
         end else if (sample_tick && voice_q[v].active) begin
            voice_d[v] = advance(voice_q[v], inc_in[v*INC_WIDTH +: INC_WIDTH],
                                 mode_in, loop_start_in, loop_end_in);
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         voice_q <= '0;
         gate_q  <= '0;
      end else begin
         voice_q <= voice_d;
         gate_q  <= gate_d;
      end
   end

   always_comb begin
      sample_addr_out = '0;
      frac_out        = '0;
      active_out      = '0;
      done_out        = '0;
      wrap_out        = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         sample_addr_out[v*ADDR_WIDTH +: ADDR_WIDTH] = voice_q[v].addr;
         frac_out[v*FRAC_WIDTH +: FRAC_WIDTH]        = voice_q[v].frac;
         active_out[v]                               = voice_q[v].active;
         done_out[v]                                 = voice_q[v].done;
         wrap_out[v]                                 = voice_q[v].wrap;
      end
   end

endmodule

// File: tb/tb_voice_sample_address_generator.sv
// Directed bench: table of voice-0 vectors plus hand sequences for polyphony, async reset
// and wide-address overshoot.
module tb_voice_sample_address_generator;

   localparam int NV = 8;
   localparam int AW = 13;
   localparam int FW = 8;
   localparam int IW = 12;

   logic             clk_in = 1'b0;
   logic             rst_n_in = 1'b0;
   logic             sample_tick = 1'b0;
   logic [NV-1:0]    gate_in = '0;
   logic [NV*IW-1:0] inc_in = '0;
   logic [1:0]       mode_in = '0;
   logic [AW-1:0]    loop_start_in = '0;
   logic [AW-1:0]    loop_end_in = '0;
   logic [NV*AW-1:0] sample_addr_out;
   logic [NV*FW-1:0] frac_out;
   logic [NV-1:0]    active_out;
   logic [NV-1:0]    done_out;
   logic [NV-1:0]    wrap_out;

   int checks = 0;
   int errors = 0;

   voice_sample_address_generator #(
      .NUM_VOICES(NV), .ADDR_WIDTH(AW), .FRAC_WIDTH(FW), .INC_WIDTH(IW)
   ) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .sample_tick(sample_tick),
      .gate_in(gate_in), .inc_in(inc_in), .mode_in(mode_in),
      .loop_start_in(loop_start_in), .loop_end_in(loop_end_in),
      .sample_addr_out(sample_addr_out), .frac_out(frac_out),
      .active_out(active_out), .done_out(done_out), .wrap_out(wrap_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      bit tick;
      bit gate;
      int inc;
      int mode;
      int ls;
      int le;
      int ea;
      int ef;
      bit eact;
      bit edone;
      bit ewrap;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(bit t, bit g, int inc, int mode, int ls, int le,
                               int ea, int ef, bit ac, bit dn, bit wr);
      vec_t x;
      x.tick = t; x.gate = g; x.inc = inc; x.mode = mode; x.ls = ls; x.le = le;
      x.ea = ea; x.ef = ef; x.eact = ac; x.edone = dn; x.ewrap = wr;
      vecs.push_back(x);
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   function automatic int addr_of(int v);
      logic [AW-1:0] a;
      a = sample_addr_out[v*AW +: AW];
      return int'(a);
   endfunction

   function automatic int frac_of(int v);
      logic [FW-1:0] f;
      f = frac_out[v*FW +: FW];
      return int'(f);
   endfunction

   function automatic int inc_of(int v);
      return v * 97 + 41;
   endfunction

   initial begin
      #600000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Voice-0 vectors: t, g, inc, mode, ls, le, addr, frac, active, done, wrap
      add(0,1,256,1,4,7, 0,0,1,0,0);
      add(1,1,256,1,4,7, 1,0,1,0,0);
      add(1,1,256,1,4,7, 2,0,1,0,0);
      add(1,1,256,1,4,7, 3,0,1,0,0);
      add(1,1,256,1,4,7, 4,0,1,0,0);
      add(1,1,256,1,4,7, 5,0,1,0,0);
      add(1,1,256,1,4,7, 6,0,1,0,0);
      add(1,1,256,1,4,7, 7,0,1,0,0);
      add(1,1,256,1,4,7, 4,0,1,0,1);
      add(1,1,256,1,4,7, 5,0,1,0,0);
      add(1,1,256,1,4,7, 6,0,1,0,0);
      add(0,0,256,1,4,7, 0,0,0,0,0);
      add(0,1,128,1,4,7, 0,0,1,0,0);
      add(1,1,128,1,4,7, 0,128,1,0,0);
      add(1,1,128,1,4,7, 1,0,1,0,0);
      add(1,1,128,1,4,7, 1,128,1,0,0);
      add(1,1,128,1,4,7, 2,0,1,0,0);
      add(1,1,256,1,4,7, 3,0,1,0,0);
      add(1,1,256,1,4,7, 4,0,1,0,0);
      add(1,1,256,1,4,7, 5,0,1,0,0);
      add(1,1,256,1,4,7, 6,0,1,0,0);
      add(1,1,256,1,4,7, 7,0,1,0,0);
      add(1,1,384,1,4,7, 4,128,1,0,1);
      add(0,0,384,1,4,7, 0,0,0,0,0);
      add(0,1,512,0,0,5, 0,0,1,0,0);
      add(1,1,512,0,0,5, 2,0,1,0,0);
      add(1,1,512,0,0,5, 4,0,1,0,0);
      add(1,1,512,0,0,5, 5,0,0,1,0);
      add(1,1,512,0,0,5, 5,0,0,0,0);
      add(1,1,512,0,0,5, 5,0,0,0,0);
      add(0,0,512,0,0,5, 0,0,0,0,0);
      add(0,1,512,0,0,5, 0,0,1,0,0);
      add(1,1,512,0,0,5, 2,0,1,0,0);
      add(0,0,256,2,2,4, 0,0,0,0,0);
      add(0,1,256,2,2,4, 0,0,1,0,0);
      add(1,1,256,2,2,4, 1,0,1,0,0);
      add(1,1,256,2,2,4, 2,0,1,0,0);
      add(1,1,256,2,2,4, 3,0,1,0,0);
      add(1,1,256,2,2,4, 4,0,1,0,0);
      add(1,1,256,2,2,4, 4,0,1,0,1);
      add(1,1,256,2,2,4, 3,0,1,0,0);
      add(1,1,256,2,2,4, 2,0,1,0,0);
      add(1,1,256,2,2,4, 2,0,1,0,1);
      add(1,1,256,2,2,4, 3,0,1,0,0);
      add(0,0,256,1,5,3, 0,0,0,0,0);
      add(0,1,256,1,5,3, 0,0,1,0,0);
      add(1,1,256,1,5,3, 1,0,1,0,0);
      add(1,1,256,1,5,3, 2,0,1,0,0);
      add(1,1,256,1,5,3, 3,0,0,1,0);
      add(1,1,256,1,5,3, 3,0,0,0,0);
      add(0,0,256,3,0,2, 0,0,0,0,0);
      add(0,1,256,3,0,2, 0,0,1,0,0);
      add(1,1,256,3,0,2, 1,0,1,0,0);
      add(1,1,256,3,0,2, 2,0,0,1,0);
      add(0,0,256,1,4,7, 0,0,0,0,0);
      add(1,1,256,1,4,7, 0,0,1,0,0);
      add(1,1,0,1,4,7,   0,0,1,0,0);
      add(1,1,0,1,4,7,   0,0,1,0,0);
      add(0,0,0,1,4,7,   0,0,0,0,0);

      #2;
      chk("rst_addr", longint'(|sample_addr_out), 0);
      chk("rst_frac", longint'(|frac_out), 0);
      chk("rst_active", longint'(|active_out), 0);
      chk("rst_done", longint'(|done_out), 0);
      chk("rst_wrap", longint'(|wrap_out), 0);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      step();

      foreach (vecs[i]) begin
         sample_tick   = vecs[i].tick;
         gate_in       = {{(NV-1){1'b0}}, vecs[i].gate};
         inc_in        = '0;
         inc_in[IW-1:0] = IW'(vecs[i].inc);
         mode_in       = 2'(vecs[i].mode);
         loop_start_in = AW'(vecs[i].ls);
         loop_end_in   = AW'(vecs[i].le);
         step();
         chk($sformatf("vec%0d_addr", i), addr_of(0), vecs[i].ea);
         chk($sformatf("vec%0d_frac", i), frac_of(0), vecs[i].ef);
         chk($sformatf("vec%0d_active", i), active_out[0], vecs[i].eact);
         chk($sformatf("vec%0d_done", i), done_out[0], vecs[i].edone);
         chk($sformatf("vec%0d_wrap", i), wrap_out[0], vecs[i].ewrap);
      end

      // Polyphony: voice 3 gates on together with a tick while the others are mid-play.
      sample_tick = 1'b0;
      gate_in = '0;
      step();
      for (int v = 0; v < NV; v++) inc_in[v*IW +: IW] = IW'(inc_of(v));
      mode_in = 2'd1;
      loop_start_in = 13'd4;
      loop_end_in = 13'd7000;
      gate_in = 8'hF7;
      step();
      sample_tick = 1'b1;
      repeat (3) step();
      gate_in = 8'hFF;
      step();
      for (int v = 0; v < NV; v++) begin
         int ph;
         ph = (v == 3) ? 0 : 4 * inc_of(v);
         chk($sformatf("poly_v%0d_addr", v), addr_of(v), ph / 256);
         chk($sformatf("poly_v%0d_frac", v), frac_of(v), ph % 256);
      end
      chk("poly_active", active_out, 8'hFF);
      step();
      chk("poly_v3_next", addr_of(3) * 256 + frac_of(3), inc_of(3));
      chk("poly_v7_next", addr_of(7) * 256 + frac_of(7), 5 * inc_of(7));

      // Asynchronous reset between clock edges.
      #2;
      rst_n_in = 1'b0;
      #1;
      chk("arst_addr", longint'(|sample_addr_out), 0);
      chk("arst_frac", longint'(|frac_out), 0);
      chk("arst_active", longint'(|active_out), 0);
      rst_n_in = 1'b1;
      step();
      chk("arst_restart_addr", longint'(|sample_addr_out), 0);
      chk("arst_restart_active", active_out, 8'hFF);
      step();
      chk("arst_first_adv", addr_of(2) * 256 + frac_of(2), inc_of(2));

      // Top-of-memory overshoot with max increment, one-shot then loop.
      sample_tick = 1'b0;
      gate_in = '0;
      step();
      for (int v = 0; v < NV; v++) inc_in[v*IW +: IW] = 12'hFFF;
      mode_in = 2'd0;
      loop_start_in = 13'd100;
      loop_end_in = 13'd8191;
      gate_in = 8'h01;
      step();
      sample_tick = 1'b1;
      repeat (512) step();
      chk("os_top_pre_addr", addr_of(0), 8190);
      chk("os_top_pre_active", active_out[0], 1);
      step();
      chk("os_top_addr", addr_of(0), 8191);
      chk("os_top_done", done_out[0], 1);
      chk("os_top_active", active_out[0], 0);
      sample_tick = 1'b0;
      gate_in = '0;
      step();
      mode_in = 2'd1;
      gate_in = 8'h01;
      step();
      sample_tick = 1'b1;
      repeat (512) step();
      chk("lp_top_pre_addr", addr_of(0), 8190);
      chk("lp_top_pre_wrap", wrap_out[0], 0);
      step();
      chk("lp_top_addr", addr_of(0), 113);
      chk("lp_top_frac", frac_of(0), 255);
      chk("lp_top_wrap", wrap_out[0], 1);
      step();
      chk("lp_top_wrap_clear", wrap_out[0], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
